hyp_req_arbiter: RTL and testbench
==================================

# hyp_req_arbiter

Round-robin arbiter and sequencer that shares one hypotenuse engine, floor(sqrt(x²+y²)), among NREQ requesters. It accepts one request at a time over per-requester valid/ready and launches the engine with a start pulse. It watches for completion with a timeout watchdog and returns the result, tagged with the requester index, on a single response channel. It sits between the client blocks and the existing sqrt/hypotenuse datapath.

## Interface
- NREQ, 4: number of requesters (2..8)
- W, 8: operand and result width
- TIMEOUT, 32: maximum WAIT cycles before abort (≥2)
- IW = max(1, clog2(NREQ)): derived index width (localparam)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_x  in  NREQ*W  requester i operand x at [i*W +: W]
- req_y  in  NREQ*W  requester i operand y at [i*W +: W]
- req_ready  out  NREQ  one-hot grant/accept; combinational; only in IDLE
- eng_start  out  1  one-cycle launch pulse to engine
- eng_x, eng_y  out  W  operands; stable from eng_start until the job ends
- eng_abort  out  1  one-cycle pulse on timeout; engine must return to idle
- eng_done  in  1  one-cycle completion pulse; eng_result valid in the same cycle
- eng_result  in  W  engine result
- rsp_valid  out  1  response available
- rsp_id  out  IW  index of the served requester
- rsp_data  out  W  result; 0 on error
- rsp_err  out  1  1 = job aborted by timeout
- rsp_ready  in  1  response consumer ready

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESP. Registers are ptr (IW), cur_id, x_q, y_q, timer, and the rsp_* registers.
- IDLE
  - grant = first i with req_valid[i], searching ptr, ptr+1, … mod NREQ.
  - If any request is valid: req_ready[grant]=1 in the same cycle, and the handshake completes.
  - On that handshake: latch x_q/y_q/cur_id, set ptr ← (grant+1) mod NREQ, go to ISSUE.
  - No request valid: stay in IDLE, req_ready=0.
- ISSUE: eng_start=1 for this cycle only, timer ← 0, go to WAIT.
- WAIT
  - eng_done=1: rsp_data ← eng_result, rsp_err ← 0, go to RESP.
  - Else if timer == TIMEOUT-1: eng_abort=1 this cycle, rsp_data ← 0, rsp_err ← 1, go to RESP.
  - Else timer ← timer+1.
- RESP
  - rsp_valid=1. rsp_id/rsp_data/rsp_err are held stable until rsp_ready=1.
  - On rsp_valid & rsp_ready, go to IDLE.
- Outside IDLE, req_ready is all 0. Requests are never accepted while a job is in flight.
- eng_done is ignored in IDLE, ISSUE and RESP.
- eng_x/eng_y are driven from x_q/y_q at all times. They change only on an IDLE handshake.
- Out-of-range NREQ indices do not exist, so ptr wraps NREQ-1 → 0.

## Timing
- Reset (rst=1 at an edge): state=IDLE, ptr=0, timer=0, cur_id=0, x_q=y_q=0. All outputs are 0: req_ready, eng_start, eng_abort, eng_x, eng_y, rsp_valid, rsp_id, rsp_data, rsp_err.
- Reset mid-job: everything is abandoned with no response and no eng_abort. The engine shares rst, so a late eng_done after reset falls in IDLE and is ignored.
- Accept at cycle T. eng_start is at T+1. WAIT begins at T+2.
- eng_done at cycle D gives rsp_valid from D+1.
- If rsp_ready is high at the first rsp_valid cycle, IDLE is reached at D+2, and the next accept can happen at D+2.
- Timeout: with no done, eng_abort fires in the TIMEOUT-th WAIT cycle (T+1+TIMEOUT), and rsp_valid follows at T+2+TIMEOUT.
- eng_done in the same cycle as the timeout: done wins, err=0, no eng_abort.
- Requester fairness: a continuously valid requester is served within NREQ grants.

## Test plan
- Single request: req_valid[0]=1, x=3, y=4; the engine model returns 5 after 10 WAIT cycles. Required: req_ready[0] at T; eng_start at T+1 with eng_x=3, eng_y=4; rsp_valid with id=0, data=5, err=0 one cycle after eng_done.
- All four requesters valid after reset with distinct operands (3/4, 5/12, 8/15, 7/24). Required: grant order 0,1,2,3 and responses 5, 13, 17, 25. Then only 0 and 2 held valid gives grants alternating 0,2,0,2.
- Backpressure: rsp_ready=0 for 6 cycles. Required: rsp_* stable, req_ready=0, no eng_start; the next grant comes the cycle after rsp_ready=1.
- Engine hang: eng_done never asserted, TIMEOUT=32. Required: eng_abort pulses exactly once at T+33; rsp err=1, data=0; the arbiter then grants the next requester.
- Edge events: eng_done coincident with timer=TIMEOUT-1 gives err=0, the real data, and no abort. A spurious eng_done in IDLE or RESP is ignored, with no state or output change.
- Reset asserted in WAIT: the next cycle shows all outputs 0 and ptr=0. A subsequent stray eng_done produces no response, and a new request from requester 3 is served normally.

Source files
------------

// File: rtl/hyp_req_arbiter.sv
// Round-robin front end for a shared hypotenuse engine: grants one requester at a time,
// launches the engine, guards it with a watchdog and returns a tagged response.
module hyp_req_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned TIMEOUT = 32,
  localparam int unsigned IW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic [NREQ-1:0]   req_ready,
  output logic              eng_start,
  output logic [W-1:0]      eng_x,
  output logic [W-1:0]      eng_y,
  output logic              eng_abort,
  input  logic              eng_done,
  input  logic [W-1:0]      eng_result,
  output logic              rsp_valid,
  output logic [IW-1:0]     rsp_id,
  output logic [W-1:0]      rsp_data,
  output logic              rsp_err,
  input  logic              rsp_ready
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   cur_id_q;
  logic [W-1:0]    x_q;
  logic [W-1:0]    y_q;
  logic [TW-1:0]   timer_q;
  logic            start_q;
  logic            rsp_valid_q;
  logic [IW-1:0]   rsp_id_q;
  logic [W-1:0]    rsp_data_q;
  logic            rsp_err_q;

  logic            grant_found;
  logic [IW-1:0]   grant_id;
  logic [IW-1:0]   scan_idx;
  logic [IW-1:0]   ptr_nxt;
  logic            timer_last;

  // Search starts at ptr and wraps, so the requester just served has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    scan_idx    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_idx = IW'((32'(ptr_q) + k) % NREQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && grant_found) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign ptr_nxt    = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);
  assign timer_last = (timer_q == TW'(TIMEOUT - 1));

  // A completion in the final watchdog cycle takes priority over the abort.
  assign eng_abort = (state_q == StWait) && !eng_done && timer_last;

  assign eng_start = start_q;
  assign eng_x     = x_q;
  assign eng_y     = y_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      cur_id_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      timer_q     <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_found) begin
            x_q      <= req_x[grant_id*W +: W];
            y_q      <= req_y[grant_id*W +: W];
            cur_id_q <= grant_id;
            ptr_q    <= ptr_nxt;
            start_q  <= 1'b1;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          timer_q <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (eng_done) begin
            rsp_data_q  <= eng_result;
            rsp_err_q   <= 1'b0;
            rsp_id_q    <= cur_id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else if (timer_last) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_id_q    <= cur_id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hyp_req_arbiter.sv
// Directed bench for hyp_req_arbiter: behavioural engine model, response scoreboard and
// cycle-accurate checks of grant order, latency, backpressure, timeout and reset.
module tb_hyp_req_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned W       = 8;
  localparam int unsigned TIMEOUT = 32;
  localparam int unsigned IW      = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [NREQ-1:0]   req_ready;
  logic              eng_start;
  logic [W-1:0]      eng_x;
  logic [W-1:0]      eng_y;
  logic              eng_abort;
  logic              eng_done;
  logic [W-1:0]      eng_result;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;
  logic              rsp_ready;

  logic              eng_done_m;
  logic [W-1:0]      eng_res_m;
  logic              spur_done;

  assign eng_done   = eng_done_m | spur_done;
  assign eng_result = spur_done ? 8'hAA : eng_res_m;

  hyp_req_arbiter #(
    .NREQ    (NREQ),
    .W       (W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_ready  (req_ready),
    .eng_start  (eng_start),
    .eng_x      (eng_x),
    .eng_y      (eng_y),
    .eng_abort  (eng_abort),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .rsp_ready  (rsp_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id;
    int data;
    int err;
  } rsp_t;

  rsp_t sb[$];
  int   grants[$];
  int   rsp_log[$];

  int n_assert = 0;
  int n_fail   = 0;
  int n_abort  = 0;
  int abort_cyc;
  int lat      = 10;
  bit hang     = 1'b0;

  function automatic int isqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Engine model: done pulses in the lat-th WAIT cycle unless the job was started in hang mode.
  initial begin
    int cnt;
    bit busy;
    bit hang_l;
    bit r;
    int res;
    cnt = 0; busy = 1'b0; hang_l = 1'b0; res = 0;
    eng_done_m = 1'b0;
    eng_res_m  = '0;
    forever begin
      @(posedge clk);
      r = rst;
      #1;
      if (r) begin
        busy       = 1'b0;
        eng_done_m = 1'b0;
      end else if (eng_start === 1'b1) begin
        busy       = 1'b1;
        cnt        = lat;
        hang_l     = hang;
        res        = isqrt(int'(eng_x) * int'(eng_x) + int'(eng_y) * int'(eng_y));
        eng_done_m = 1'b0;
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          busy       = 1'b0;
          eng_done_m = !hang_l;
          eng_res_m  = W'(res);
        end else begin
          eng_done_m = 1'b0;
        end
      end else begin
        eng_done_m = 1'b0;
      end
    end
  end

  // Monitor: records grants, pushes expected responses at accept, pops them at response.
  initial begin
    int   gid;
    int   acc_x;
    int   acc_y;
    bit   prev_valid;
    bit   prev_ready;
    logic [IW-1:0] prev_id;
    logic [W-1:0]  prev_data;
    logic          prev_err;
    rsp_t e;
    gid = 0; acc_x = 0; acc_y = 0; prev_valid = 1'b0; prev_ready = 1'b0;
    prev_id = '0; prev_data = '0; prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        if (req_ready !== '0) begin
          check("grant_onehot", 32'($onehot(req_ready)), 1);
          for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
          grants.push_back(gid);
          acc_x = int'(req_x[gid*W +: W]);
          acc_y = int'(req_y[gid*W +: W]);
          e.id   = gid;
          e.data = hang ? 0 : isqrt(acc_x * acc_x + acc_y * acc_y);
          e.err  = hang ? 1 : 0;
          sb.push_back(e);
        end
        if (eng_start === 1'b1) begin
          check("start_eng_x", eng_x, acc_x);
          check("start_eng_y", eng_y, acc_y);
        end
        if (eng_abort === 1'b1) begin
          n_abort++;
          abort_cyc = cyc;
        end
        if (rsp_valid === 1'b1) begin
          check("resp_no_grant", req_ready, 0);
          check("resp_no_start", eng_start, 0);
          if (prev_valid && !prev_ready) begin
            check("hold_id", rsp_id, prev_id);
            check("hold_data", rsp_data, prev_data);
            check("hold_err", rsp_err, prev_err);
          end
          if (rsp_ready === 1'b1) begin
            check("sb_pending", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              check("sb_id", rsp_id, e.id);
              check("sb_data", rsp_data, e.data);
              check("sb_err", rsp_err, e.err);
            end
            rsp_log.push_back(int'(rsp_data));
          end
        end
        prev_valid = (rsp_valid === 1'b1);
        prev_ready = (rsp_ready === 1'b1);
        prev_id    = rsp_id;
        prev_data  = rsp_data;
        prev_err   = rsp_err;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #1;
  endtask

  task automatic set_op(input int i, input int x, input int y);
    req_x[i*W +: W] = W'(x);
    req_y[i*W +: W] = W'(y);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int k;
    k = 0;
    while (rsp_valid !== 1'b1 && k < budget) begin
      step(); look(); k++;
    end
    check(tag, rsp_valid, 1);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int k;
    k = 0;
    while ((sb.size() != 0 || rsp_valid === 1'b1) && k < budget) begin
      step(); look(); k++;
    end
    check(tag, sb.size(), 0);
  endtask

  task automatic wait_grants(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (grants.size() < n && k < budget) begin
      step(); look(); k++;
    end
    check(tag, grants.size(), n);
  endtask

  task automatic check_zero(input string p);
    check({p, "_req_ready"}, req_ready, 0);
    check({p, "_eng_start"}, eng_start, 0);
    check({p, "_eng_abort"}, eng_abort, 0);
    check({p, "_eng_x"}, eng_x, 0);
    check({p, "_eng_y"}, eng_y, 0);
    check({p, "_rsp_valid"}, rsp_valid, 0);
    check({p, "_rsp_id"}, rsp_id, 0);
    check({p, "_rsp_data"}, rsp_data, 0);
    check({p, "_rsp_err"}, rsp_err, 0);
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    int t;
    int ab0;
    int exp_hyp[4];
    int exp_alt[4];
    exp_hyp = '{5, 13, 17, 25};
    exp_alt = '{0, 2, 0, 2};
    rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0;
    rsp_ready = 1'b1; spur_done = 1'b0;

    // Reset state
    step(); step(); look();
    check_zero("reset");
    step(); rst = 1'b0;

    // Single request, 10-cycle engine
    step(); lat = 10; set_op(0, 3, 4); req_valid = 4'b0001; look();
    check("t1_ready", req_ready, 4'b0001);
    t = cyc;
    step(); req_valid = '0; look();
    check("t1_start", eng_start, 1);
    check("t1_eng_x", eng_x, 3);
    check("t1_eng_y", eng_y, 4);
    wait_valid(40, "t1_valid");
    check("t1_rsp_cycle", cyc, t + 12);
    check("t1_rsp_id", rsp_id, 0);
    check("t1_rsp_data", rsp_data, 5);
    check("t1_rsp_err", rsp_err, 0);
    step(); look();
    check("t1_start_once", eng_start, 0);
    wait_drain(10, "t1_drain");

    // All four after reset, then 0 and 2 alternating
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    grants.delete(); rsp_log.delete(); lat = 3;
    set_op(0, 3, 4); set_op(1, 5, 12); set_op(2, 8, 15); set_op(3, 7, 24);
    req_valid = 4'b1111;
    wait_grants(4, 100, "t2_grants");
    step(); req_valid = '0;
    wait_drain(60, "t2_drain");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_grant%0d", i), q_at(grants, i), i);
      check($sformatf("t2_data%0d", i), q_at(rsp_log, i), exp_hyp[i]);
    end
    step(); grants.delete(); req_valid = 4'b0101;
    wait_grants(4, 100, "t2b_grants");
    step(); req_valid = '0;
    wait_drain(60, "t2b_drain");
    for (int i = 0; i < 4; i++) check($sformatf("t2b_grant%0d", i), q_at(grants, i), exp_alt[i]);

    // Backpressure on response
    step(); rsp_ready = 1'b0; set_op(1, 6, 8); req_valid = 4'b0010; look();
    check("t3_ready", req_ready, 4'b0010);
    step(); req_valid = 4'b1000; set_op(3, 9, 12);
    wait_valid(20, "t3_valid");
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin step(); look(); end
      check("t3_hold_valid", rsp_valid, 1);
      check("t3_hold_data", rsp_data, 10);
      check("t3_hold_id", rsp_id, 1);
      check("t3_no_grant", req_ready, 0);
    end
    step(); rsp_ready = 1'b1; look();
    check("t3_valid_at_ready", rsp_valid, 1);
    step(); look();
    check("t3_next_grant", req_ready, 4'b1000);
    step(); req_valid = '0;
    wait_drain(20, "t3_drain");

    // Engine hang
    step(); hang = 1'b1; set_op(0, 1, 1); req_valid = 4'b0001; look();
    check("t4_ready", req_ready, 4'b0001);
    t = cyc; ab0 = n_abort;
    step(); req_valid = 4'b0010; set_op(1, 20, 21);
    wait_valid(50, "t4_valid");
    check("t4_abort_count", n_abort, ab0 + 1);
    check("t4_abort_cycle", abort_cyc, t + 33);
    check("t4_rsp_cycle", cyc, t + 34);
    check("t4_rsp_err", rsp_err, 1);
    check("t4_rsp_data", rsp_data, 0);
    check("t4_rsp_id", rsp_id, 0);
    step(); hang = 1'b0; lat = 3; look();
    check("t4_next_grant", req_ready, 4'b0010);
    step(); req_valid = '0;
    wait_drain(20, "t4_drain");
    check("t4_abort_once", n_abort, ab0 + 1);

    // Done coincident with the last watchdog cycle
    step(); lat = TIMEOUT; set_op(2, 12, 16); req_valid = 4'b0100; look();
    check("t5_ready", req_ready, 4'b0100);
    t = cyc; ab0 = n_abort;
    step(); req_valid = '0;
    wait_valid(50, "t5_valid");
    check("t5_rsp_cycle", cyc, t + 34);
    check("t5_rsp_err", rsp_err, 0);
    check("t5_rsp_data", rsp_data, 20);
    check("t5_no_abort", n_abort, ab0);
    wait_drain(10, "t5_drain");

    // Spurious done in IDLE and in RESP
    step(); spur_done = 1'b1; look();
    check("sp_idle_valid0", rsp_valid, 0);
    step(); spur_done = 1'b0; look();
    check("sp_idle_valid1", rsp_valid, 0);
    check("sp_idle_start", eng_start, 0);
    check("sp_idle_abort", eng_abort, 0);
    step(); lat = 2; rsp_ready = 1'b0; set_op(3, 8, 6); req_valid = 4'b1000; look();
    check("sp_ready", req_ready, 4'b1000);
    step(); req_valid = '0;
    wait_valid(20, "sp_valid");
    step(); spur_done = 1'b1; look();
    check("sp_resp_data0", rsp_data, 10);
    step(); spur_done = 1'b0; look();
    check("sp_resp_valid", rsp_valid, 1);
    check("sp_resp_data1", rsp_data, 10);
    check("sp_resp_err", rsp_err, 0);
    check("sp_resp_id", rsp_id, 3);
    step(); rsp_ready = 1'b1;
    wait_drain(10, "sp_drain");

    // Reset in WAIT
    step(); lat = 20; set_op(1, 5, 5); req_valid = 4'b0010; look();
    check("t6_ready", req_ready, 4'b0010);
    ab0 = n_abort;
    step(); req_valid = '0;
    repeat (5) step();
    rst = 1'b1;
    step(); rst = 1'b0; look();
    check_zero("t6");
    sb.delete();
    step(); spur_done = 1'b1; look();
    check("t6_stray0", rsp_valid, 0);
    step(); spur_done = 1'b0; look();
    check("t6_stray1", rsp_valid, 0);
    step(); look();
    check("t6_stray2", rsp_valid, 0);
    check("t6_no_abort", n_abort, ab0);
    grants.delete(); rsp_log.delete();
    step(); lat = 4; set_op(1, 5, 12); set_op(3, 9, 40); req_valid = 4'b1010; look();
    check("t6_ptr_reset", req_ready, 4'b0010);
    step(); req_valid = 4'b1000;
    wait_grants(2, 60, "t6_grants");
    step(); req_valid = '0;
    wait_drain(30, "t6_drain");
    check("t6_grant_req3", q_at(grants, 1), 3);
    check("t6_data0", q_at(rsp_log, 0), 13);
    check("t6_data1", q_at(rsp_log, 1), 41);
    check("total_aborts", n_abort, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
